ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 82 ++++++++
 tb/tb_ifetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: walks fetch_pc through an asynchronous instruction memory
// and buffers {pc, instruction} pairs in a small FIFO for the decode stage.
module ifetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] pc_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] ins_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] redirect_target;

  // Handshake: the head transfers on any edge where instr_valid and instr_ready are
  // both high; instr_valid never depends on instr_ready, and the head stays stable
  // until it is taken (or discarded by rst/redirect).
  assign full            = (count == CNT_W'(DEPTH));
  assign instr_valid     = (count != '0);
  assign pop             = instr_valid & instr_ready;
  assign push            = ~rst & ~redirect_valid & (~full | pop);
  assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);
  assign imem_addr       = fetch_pc;
  assign instr           = instr_valid ? ins_mem[rd_ptr] : '0;
  assign instr_pc        = instr_valid ? pc_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // A redirect drops everything buffered, even a head the consumer takes now.
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + DATA_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a random-ready/redirect soak,
// checked by an in-order scoreboard of expected {pc, instruction} pairs.
module tb_ifetch_unit;

  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] KEY      = 32'hA5C30F96;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [DW-1:0] instr_pc;

  logic [DW-1:0]   mem_key;
  logic [2*DW-1:0] exp_q[$];
  int              checks   = 0;
  int              failures = 0;
  int              pops     = 0;

  ifetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // Clock and memory model: the word at an address is the address XOR a key.
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ mem_key;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ mem_key});
  endtask

  // Cycle inputs forward until the scoreboard has consumed every expected entry.
  task automatic drain(input string name, input int exp_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    instr_ready = 1'b0;
    check(name, n, exp_cycles);
  endtask

  task automatic hold_reset(input int edges);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    exp_q.delete();
    repeat (edges) @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the coming edge whenever valid and ready are high now.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h/%h required=none", instr_pc, instr);
      end else begin
        check("sb_head", {instr_pc, instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] gen_pc;
    logic [31:0] target;
    logic [63:0] front;
    logic        rdy;

    mem_key     = '0;
    redirect_pc = '0;
    hold_reset(2);

    // Post-reset state, rst still high.
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_imem_addr", imem_addr, RESET_PC);

    // Word equals address, ready always high.
    expect_pc(32'hBFC00000); expect_pc(32'hBFC00004); expect_pc(32'hBFC00008);
    instr_ready = 1'b1;
    rst         = 1'b0;
    drain("stream_cycles", 4);

    // Backpressure: FIFO fills to two entries and fetch stalls.
    mem_key = KEY;
    hold_reset(2);
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("bp_imem_addr", imem_addr, 32'hBFC00008);
    check("bp_head_pc", instr_pc, 32'hBFC00000);
    check("bp_head_instr", instr, 32'hBFC00000 ^ KEY);
    check("bp_valid", instr_valid, 1);
    for (int i = 0; i < 6; i++) expect_pc(32'hBFC00000 + 32'(4 * i));
    instr_ready = 1'b1;
    drain("bp_drain_cycles", 6);

    // Redirect to an unaligned target while full.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00000103;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    check("redir_flush_valid", instr_valid, 0);
    check("redir_imem_addr", imem_addr, 32'h00000100);
    @(posedge clk); #1;
    check("redir_first_pc", instr_pc, 32'h00000100);
    check("redir_first_valid", instr_valid, 1);
    expect_pc(32'h00000100); expect_pc(32'h00000104);
    instr_ready = 1'b1;
    drain("redir_drain_cycles", 2);

    // Redirect with the head consumed in the same cycle, target at the wrap point.
    @(posedge clk); #1;
    expect_pc(32'h00000108);
    expect_pc(32'hFFFFFFFC); expect_pc(32'h00000000); expect_pc(32'h00000004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    instr_ready    = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drain("wrap_drain_cycles", 4);

    // Reset and redirect together mid-stream: reset wins.
    hold_reset(0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00001000;
    @(posedge clk); #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    check("rr_valid", instr_valid, 0);
    check("rr_instr", instr, 0);
    check("rr_pc", instr_pc, 0);
    check("rr_imem_addr", imem_addr, RESET_PC);
    expect_pc(32'hBFC00000); expect_pc(32'hBFC00004);
    instr_ready = 1'b1;
    drain("rr_drain_cycles", 3);

    // Soak: random ready, occasional (sometimes back-to-back) redirects.
    hold_reset(2);
    rst    = 1'b0;
    gen_pc = RESET_PC;
    pops   = 0;
    for (int c = 0; c < 1000; c++) begin
      rdy            = 1'($urandom_range(0, 1));
      instr_ready    = rdy;
      redirect_valid = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        target         = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15))
                                                     : $urandom;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        if (instr_valid && rdy && exp_q.size() != 0) begin
          front = exp_q[0];
          exp_q.delete();
          exp_q.push_back(front);
        end else begin
          exp_q.delete();
        end
        gen_pc = {target[31:2], 2'b00};
      end
      while (exp_q.size() < 4) begin
        expect_pc(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
      @(posedge clk); #1;
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    check("soak_progress", pops > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
